// File: rtl/mx_cpu_pkt_arb_pkg.sv
// Shared types and the round-robin pick function for the CPU packet arbiter.
// The package name is the one the rest of the codebase imports.
package mx_cpu_arb_pkg;

    localparam int RR_MAX_PORTS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // First set bit of req strictly after ptr, wrapping. Bits above the real
    // port count must be zero, which makes the 16-wide wrap equal to a PORT_CNT wrap.
    function automatic logic [3:0] rr_next(input logic [RR_MAX_PORTS-1:0] req,
                                           input logic [3:0]              ptr);
        logic [3:0] idx;
        rr_next = ptr;
        for (int k = RR_MAX_PORTS; k >= 1; k--) begin
            idx = ptr + 4'(k);
            if (req[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/mx_cpu_pkt_arb_if.sv
// Per-port input streams and the merged CPU-bound output stream of mx_cpu_pkt_arb.
interface mx_cpu_pkt_arb_if #(
    parameter int PORT_CNT = 4,
    parameter int DATA_W   = 64,
    parameter int EMPTY_W  = 3,
    parameter int PORT_W   = 2
);
    logic [PORT_CNT*DATA_W-1:0]  in_data_i;
    logic [PORT_CNT-1:0]         in_valid_i;
    logic [PORT_CNT-1:0]         in_sop_i;
    logic [PORT_CNT-1:0]         in_eop_i;
    logic [PORT_CNT*EMPTY_W-1:0] in_empty_i;
    logic [PORT_CNT-1:0]         in_ready_o;
    logic [DATA_W-1:0]           out_data_o;
    logic [EMPTY_W-1:0]          out_empty_o;
    logic                        out_valid_o;
    logic                        out_sop_o;
    logic                        out_eop_o;
    logic [PORT_W-1:0]           out_port_o;
    logic                        out_ready_i;

    modport slave (
        input  in_data_i, in_valid_i, in_sop_i, in_eop_i, in_empty_i, out_ready_i,
        output in_ready_o, out_data_o, out_empty_o, out_valid_o, out_sop_o, out_eop_o,
        out_port_o
    );

    modport master (
        output in_data_i, in_valid_i, in_sop_i, in_eop_i, in_empty_i, out_ready_i,
        input  in_ready_o, out_data_o, out_empty_o, out_valid_o, out_sop_o, out_eop_o,
        out_port_o
    );
endinterface

// File: rtl/mx_cpu_pkt_arb_rr.sv
// Round-robin priority picker: holds the last-served pointer and offers the
// next requester after it. The pointer moves only when load_i is pulsed.
module mx_rr_arbiter
    import mx_cpu_arb_pkg::*;
#(
    parameter int PORT_CNT = 4,
    parameter int PORT_W   = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [PORT_CNT-1:0] req_i,
    input  logic                load_i,
    input  logic [PORT_W-1:0]   load_idx_i,
    output logic [PORT_W-1:0]   grant_o,
    output logic                any_req_o
);
    logic [PORT_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) ptr_d = load_idx_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= PORT_W'(PORT_CNT - 1);
        else          ptr_q <= ptr_d;
    end

    assign grant_o   = PORT_W'(rr_next(RR_MAX_PORTS'(req_i), 4'(ptr_q)));
    assign any_req_o = |req_i;
endmodule

// File: rtl/mx_cpu_pkt_arb.sv
// Packet-atomic round-robin merge of per-port CPU streams into one tagged stream,
// with per-port enable, hardware flush of disabled/orphan traffic and statistics.
module mx_cpu_pkt_arb
    import mx_cpu_arb_pkg::*;
#(
    parameter int PORT_CNT = 4,
    parameter int DATA_W   = 64,
    parameter int EMPTY_W  = 3,
    parameter int CNT_W    = 32,
    parameter int PORT_W   = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1
) (
    input  logic                clk_156m25_i,
    input  logic                rst_n_i,
    mx_cpu_pkt_arb_if.slave     bus,
    input  logic [PORT_CNT-1:0] port_en_i,
    input  logic [PORT_CNT-1:0] cnt_clr_i,
    input  logic [PORT_W-1:0]   stat_sel_i,
    output logic [CNT_W-1:0]    pkt_cnt_o,
    output logic [CNT_W-1:0]    drop_cnt_o
);
    arb_state_t          state_q, state_d;
    logic [PORT_W-1:0]   grant_q, grant_d, rr_grant;
    logic                any_req, load;
    logic [PORT_CNT-1:0] req, flush, ready, flushing_q, flushing_d;
    logic [CNT_W-1:0]    pkt_cnt_q [PORT_CNT];
    logic [CNT_W-1:0]    pkt_cnt_d [PORT_CNT];
    logic [CNT_W-1:0]    drop_cnt_q [PORT_CNT];
    logic [CNT_W-1:0]    drop_cnt_d [PORT_CNT];
    logic [CNT_W-1:0]    pkt_rd_q, pkt_rd_d, drop_rd_q, drop_rd_d;
    logic [DATA_W-1:0]   out_data;
    logic [EMPTY_W-1:0]  out_empty;
    logic                out_valid, out_sop, out_eop;

    // Any port not currently owning the output is either requesting, idle, or flushed.
    always_comb begin
        for (int i = 0; i < PORT_CNT; i++) begin
            req[i]   = bus.in_valid_i[i] && bus.in_sop_i[i] && port_en_i[i] && !flushing_q[i];
            flush[i] = !(state_q == XFER && grant_q == PORT_W'(i)) &&
                       (flushing_q[i] || !port_en_i[i] || (bus.in_valid_i[i] && !bus.in_sop_i[i]));
        end
    end

    mx_rr_arbiter #(
        .PORT_CNT (PORT_CNT),
        .PORT_W   (PORT_W)
    ) u_rr (
        .clk_i      (clk_156m25_i),
        .rst_n_i    (rst_n_i),
        .req_i      (req),
        .load_i     (load),
        .load_idx_i (grant_q),
        .grant_o    (rr_grant),
        .any_req_o  (any_req)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        flushing_d = flushing_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        load       = 1'b0;
        ready      = flush;
        out_data   = '0;
        out_empty  = '0;
        out_valid  = 1'b0;
        out_sop    = 1'b0;
        out_eop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = rr_grant;
                    state_d = XFER;
                end
            end
            XFER: begin
                out_data         = bus.in_data_i[grant_q*DATA_W +: DATA_W];
                out_empty        = bus.in_empty_i[grant_q*EMPTY_W +: EMPTY_W];
                out_valid        = bus.in_valid_i[grant_q];
                out_sop          = bus.in_sop_i[grant_q];
                out_eop          = bus.in_eop_i[grant_q];
                ready[grant_q]   = bus.out_ready_i;
                if (out_valid && out_eop && bus.out_ready_i) begin
                    load               = 1'b1;
                    state_d            = IDLE;
                    pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Flushed ports always accept, so every valid beat there is consumed.
        for (int i = 0; i < PORT_CNT; i++) begin
            if (flush[i] && bus.in_valid_i[i]) begin
                flushing_d[i] = !bus.in_eop_i[i];
                if (bus.in_eop_i[i]) drop_cnt_d[i] = drop_cnt_q[i] + CNT_W'(1);
            end
            if (cnt_clr_i[i]) begin
                pkt_cnt_d[i]  = '0;
                drop_cnt_d[i] = '0;
            end
        end

        pkt_rd_d  = '0;
        drop_rd_d = '0;
        if (int'(stat_sel_i) < PORT_CNT) begin
            pkt_rd_d  = pkt_cnt_q[stat_sel_i];
            drop_rd_d = drop_cnt_q[stat_sel_i];
        end
    end

    always_ff @(posedge clk_156m25_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            flushing_q <= '0;
            pkt_cnt_q  <= '{default: '0};
            drop_cnt_q <= '{default: '0};
            pkt_rd_q   <= '0;
            drop_rd_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            flushing_q <= flushing_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            pkt_rd_q   <= pkt_rd_d;
            drop_rd_q  <= drop_rd_d;
        end
    end

    // Disabled ports keep draining even while the block is held in reset.
    assign bus.in_ready_o  = rst_n_i ? ready : ~port_en_i;
    assign bus.out_data_o  = out_data;
    assign bus.out_empty_o = out_empty;
    assign bus.out_valid_o = out_valid;
    assign bus.out_sop_o   = out_sop;
    assign bus.out_eop_o   = out_eop;
    assign bus.out_port_o  = grant_q & {PORT_W{state_q == XFER}};
    assign pkt_cnt_o       = pkt_rd_q;
    assign drop_cnt_o      = drop_rd_q;
endmodule

// File: tb/tb_mx_cpu_pkt_arb.sv
// Bench for mx_cpu_pkt_arb: per-port packet sources, a transaction-level arbiter
// model compared every cycle, and directed scenarios with literal expectations.
module tb_mx_cpu_pkt_arb;
    localparam int N       = 4;
    localparam int DATA_W  = 64;
    localparam int EMPTY_W = 3;
    localparam int CNT_W   = 32;
    localparam int PORT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      port_en = '1;
    logic [N-1:0]      cnt_clr = '0;
    logic [PORT_W-1:0] stat_sel = '0;
    logic [CNT_W-1:0]  pkt_cnt_o, drop_cnt_o;

    mx_cpu_pkt_arb_if #(.PORT_CNT(N), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .PORT_W(PORT_W)) bus ();

    mx_cpu_pkt_arb #(.PORT_CNT(N), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CNT_W(CNT_W),
                     .PORT_W(PORT_W)) dut (
        .clk_156m25_i (clk),
        .rst_n_i      (rst_n),
        .bus          (bus),
        .port_en_i    (port_en),
        .cnt_clr_i    (cnt_clr),
        .stat_sel_i   (stat_sel),
        .pkt_cnt_o    (pkt_cnt_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct { int len; bit orphan; } pkt_t;
    typedef struct { int cyc; int port; bit sop; bit eop; int beat; } beat_t;

    // sources
    pkt_t               pq [N][$];
    bit                 pend [N];
    bit                 s_sop [N], s_eop [N];
    logic [DATA_W-1:0]  s_data [N];
    logic [EMPTY_W-1:0] s_empty [N];
    int                 s_beat [N];
    int                 cur_left [N], cur_beat [N], pkt_id [N];
    bit                 cur_orphan [N];
    bit                 gaps = 0;
    bit                 xf [N];

    // model
    int                 owner = -1;
    int                 ptr = N - 1;
    bit                 flushing [N];
    logic [CNT_W-1:0]   m_pkt [N], m_drop [N];
    logic [CNT_W-1:0]   exp_pkt_o = '0, exp_drop_o = '0;
    int                 cyc = 0;
    beat_t              log_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic qpkt(input int port, input int len, input bit orphan);
        pkt_t p;
        p.len = len;
        p.orphan = orphan;
        pq[port].push_back(p);
    endtask

    task automatic drive();
        pkt_t p;
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
                if (cur_left[i] == 0 && pq[i].size() > 0 && (!gaps || $urandom_range(1, 0) == 1)) begin
                    p = pq[i].pop_front();
                    cur_left[i] = p.len;
                    cur_beat[i] = 0;
                    cur_orphan[i] = p.orphan;
                    pkt_id[i]++;
                end
                if (cur_left[i] > 0 && (!gaps || $urandom_range(4, 0) != 0)) begin
                    pend[i]    = 1;
                    s_sop[i]   = (cur_beat[i] == 0) && !cur_orphan[i];
                    s_eop[i]   = (cur_left[i] == 1);
                    s_data[i]  = {8'(i), 24'(pkt_id[i]), 16'(cur_beat[i]), 16'($urandom)};
                    s_empty[i] = s_eop[i] ? EMPTY_W'($urandom) : '0;
                    s_beat[i]  = cur_beat[i];
                end
            end
            bus.in_valid_i[i] = pend[i];
            bus.in_sop_i[i]   = s_sop[i];
            bus.in_eop_i[i]   = s_eop[i];
            bus.in_data_i[i*DATA_W +: DATA_W]    = s_data[i];
            bus.in_empty_i[i*EMPTY_W +: EMPTY_W] = s_empty[i];
        end
    endtask

    task automatic step();
        logic [N-1:0]     er;
        bit               rdy [N];
        bit               ev;
        int               nxt, sel;
        logic [CNT_W-1:0] nx_pkt, nx_drop;
        beat_t            b;
        #1;
        if (!rst_n) begin
            owner = -1;
            ptr = N - 1;
            for (int i = 0; i < N; i++) begin
                flushing[i] = 0;
                m_pkt[i] = '0;
                m_drop[i] = '0;
            end
            exp_pkt_o = '0;
            exp_drop_o = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (!rst_n)          rdy[i] = !port_en[i];
            else if (i == owner) rdy[i] = bus.out_ready_i;
            else                 rdy[i] = flushing[i] || !port_en[i] || (pend[i] && !s_sop[i]);
            er[i] = rdy[i];
        end
        ev = rst_n && owner >= 0 && pend[owner];
        chk("in_ready", bus.in_ready_o, er);
        chk("out_valid", bus.out_valid_o, ev);
        if (ev) begin
            chk("out_sop", bus.out_sop_o, s_sop[owner]);
            chk("out_eop", bus.out_eop_o, s_eop[owner]);
            chk("out_data", bus.out_data_o, s_data[owner]);
            chk("out_empty", bus.out_empty_o, s_empty[owner]);
            chk("out_port", bus.out_port_o, owner);
        end else if (!rst_n) begin
            chk("rst_out_data", bus.out_data_o, 0);
            chk("rst_out_port", bus.out_port_o, 0);
            chk("rst_out_sop_eop", {bus.out_sop_o, bus.out_eop_o, bus.out_empty_o}, 0);
        end
        chk("pkt_cnt_o", pkt_cnt_o, exp_pkt_o);
        chk("drop_cnt_o", drop_cnt_o, exp_drop_o);
        for (int i = 0; i < N; i++) xf[i] = pend[i] && rdy[i];
        if (rst_n) begin
            sel = int'(stat_sel);
            nx_pkt = m_pkt[sel];
            nx_drop = m_drop[sel];
            nxt = owner;
            if (owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int p;
                    p = (ptr + k) % N;
                    if (nxt < 0 && pend[p] && s_sop[p] && port_en[p] && !flushing[p]) nxt = p;
                end
            end else if (xf[owner]) begin
                b.cyc = cyc; b.port = owner; b.sop = s_sop[owner];
                b.eop = s_eop[owner]; b.beat = s_beat[owner];
                log_q.push_back(b);
                if (s_eop[owner]) begin
                    m_pkt[owner] += 1;
                    ptr = owner;
                    nxt = -1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (i != owner && xf[i]) begin
                    if (s_eop[i]) begin
                        m_drop[i] += 1;
                        flushing[i] = 0;
                    end else begin
                        flushing[i] = 1;
                    end
                end
                if (cnt_clr[i]) begin
                    m_pkt[i] = '0;
                    m_drop[i] = '0;
                end
            end
            owner = nxt;
            exp_pkt_o = nx_pkt;
            exp_drop_o = nx_drop;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic advance();
        for (int i = 0; i < N; i++) begin
            if (xf[i]) begin
                pend[i] = 0;
                cur_left[i]--;
                cur_beat[i]++;
            end
        end
    endtask

    task automatic cycle();
        drive();
        step();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic read_cnt(input string tag, input int sel, input int ep, input int ed);
        stat_sel = PORT_W'(sel);
        cycle();
        cycle();
        #1;
        chk({tag, "_pkt"}, pkt_cnt_o, ep);
        chk({tag, "_drop"}, drop_cnt_o, ed);
    endtask

    initial begin : main
        int c0, nsop;
        int exp_ports [6] = '{0, 1, 3, 0, 1, 3};
        bus.out_ready_i = 1'b1;
        @(negedge clk);

        // reset: ready mirrors ~port_en, everything else zero
        repeat (2) cycle();
        port_en = 4'b0101;
        cycle();
        #1 chk("rst_ready", bus.in_ready_o, 4'b1010);
        port_en = '1;
        rst_n = 1'b1;

        // single 3-beat packet on port 2
        log_q.delete();
        c0 = cyc;
        qpkt(2, 3, 0);
        repeat (6) cycle();
        chk("t1_beats", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t1_first_cyc", log_q[0].cyc - c0, 1);
            chk("t1_last_cyc", log_q[2].cyc - c0, 3);
            chk("t1_port", log_q[0].port, 2);
            chk("t1_sop_eop", {log_q[0].sop, log_q[2].eop}, 2'b11);
        end
        read_cnt("t1", 2, 1, 0);

        // round robin over ports 0,1,3 with two 2-beat packets each
        do_reset();
        log_q.delete();
        for (int r = 0; r < 2; r++) begin
            qpkt(0, 2, 0);
            qpkt(1, 2, 0);
            qpkt(3, 2, 0);
        end
        c0 = cyc;
        repeat (20) cycle();
        nsop = 0;
        foreach (log_q[j]) begin
            if (log_q[j].sop) begin
                if (nsop < 6) begin
                    chk("t2_port", log_q[j].port, exp_ports[nsop]);
                    chk("t2_sop_cyc", log_q[j].cyc - c0, 1 + 3 * nsop);
                end
                nsop++;
            end
        end
        chk("t2_pkts", nsop, 6);

        // backpressure: out_ready toggles during the packet
        do_reset();
        log_q.delete();
        qpkt(0, 4, 0);
        for (int k = 0; k < 14; k++) begin
            bus.out_ready_i = (k % 2 == 0);
            cycle();
        end
        bus.out_ready_i = 1'b1;
        chk("t3_beats", log_q.size(), 4);
        foreach (log_q[j]) chk("t3_beat_order", log_q[j].beat, j);

        // disabled port is flushed and counted
        do_reset();
        log_q.delete();
        port_en = 4'b1101;
        for (int r = 0; r < 4; r++) qpkt(1, 2, 0);
        repeat (12) cycle();
        port_en = '1;
        chk("t4_no_output", log_q.size(), 0);
        read_cnt("t4_dis", 1, 0, 4);

        // disable the granted port mid-packet: the packet still completes
        do_reset();
        log_q.delete();
        qpkt(3, 4, 0);
        repeat (2) cycle();
        port_en = 4'b0111;
        repeat (6) cycle();
        port_en = '1;
        chk("t4_mid_beats", log_q.size(), 4);
        if (log_q.size() == 4) chk("t4_mid_last", {log_q[3].port, log_q[3].eop}, {32'd3, 1'b1});
        read_cnt("t4_mid", 3, 1, 0);

        // orphan beats then a proper packet
        do_reset();
        log_q.delete();
        qpkt(0, 2, 1);
        qpkt(0, 2, 0);
        repeat (8) cycle();
        chk("t5_beats", log_q.size(), 2);
        if (log_q.size() == 2) chk("t5_sop", log_q[0].sop, 1);
        read_cnt("t5", 0, 1, 1);

        // counter clear coinciding with the eop on port 2
        do_reset();
        log_q.delete();
        qpkt(2, 2, 0);
        c0 = cyc;
        repeat (2) cycle();
        cnt_clr = 4'b0100;
        cycle();
        cnt_clr = '0;
        chk("t6_beats", log_q.size(), 2);
        if (log_q.size() == 2) chk("t6_eop_cyc", log_q[1].cyc - c0, 2);
        read_cnt("t6_clr", 2, 0, 0);
        qpkt(2, 2, 0);
        repeat (4) cycle();
        read_cnt("t6_after", 2, 1, 0);

        // randomized traffic with enable churn, clears, backpressure and a mid-run reset
        do_reset();
        gaps = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++)
                if (pq[i].size() == 0) qpkt(i, $urandom_range(5, 1), $urandom_range(11, 0) == 0);
            bus.out_ready_i = ($urandom_range(3, 0) != 0);
            if ($urandom_range(39, 0) == 0) port_en[$urandom_range(N-1, 0)] ^= 1'b1;
            if ($urandom_range(29, 0) == 0) cnt_clr[$urandom_range(N-1, 0)] = 1'b1;
            stat_sel = PORT_W'($urandom_range(N-1, 0));
            if (n == 1500) rst_n = 1'b0;
            if (n == 1502) rst_n = 1'b1;
            cycle();
            cnt_clr = '0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
